stream_mux_arb: RTL

- Parametrised successor to the team's combinational four-way multiplexer.
- Selects one of N_CH valid/ready input streams, each WIDTH bits wide, and forwards it through a registered output stage.
- Two selection modes: fixed select (sel drives the choice, as in the combinational mux) and round-robin arbitration.
- Sits between multiple requesters (e.g. bus masters, debug sources) and a single shared consumer.

---
 rtl/stream_mux_arb.sv | 55 +++++
 1 files changed

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N_CH-way valid/ready stream mux with fixed-select or round-robin choice and a registered output stage
module stream_mux_arb #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 8,
   localparam int CH_W = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mode,
   input  logic [CH_W-1:0]       sel,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
   input  logic [N_CH*WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [CH_W-1:0]       out_ch
);
   logic            load, hit, rr_hit, fx_hit;
   logic [CH_W-1:0] last, rr_g, g;
   assign load   = !out_valid || out_ready;
   assign fx_hit = (int'(sel) < N_CH) && in_valid[sel];
   // descending scan so the channel closest after last wins
   always_comb begin
      rr_hit = 1'b0;
      rr_g   = '0;
      for (int k = N_CH; k >= 1; k--) begin
         if (in_valid[(int'(last) + k) % N_CH]) begin
            rr_hit = 1'b1;
            rr_g   = CH_W'((int'(last) + k) % N_CH);
         end
      end
   end
   assign hit = mode ? rr_hit : fx_hit;
   assign g   = mode ? rr_g : sel;
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N_CH; i++) in_ready[i] = hit && load && (g == CH_W'(i));
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         last      <= CH_W'(N_CH - 1);
      end else if (load) begin
         out_valid <= hit;
         if (hit) begin
            out_data <= in_data[g*WIDTH +: WIDTH];
            out_ch   <= g;
            if (mode) last <= g;
         end
      end
   end
endmodule
